// File: rtl/fetch_stage.sv
// Front-end fetch stage: PC generation, 1-cycle instruction memory requests,
// and an in-order fetch queue presented to decode.
//
// Handshake: each valid/ready pair transfers a beat only in a cycle where both
// are high; imem has no ready (a request is taken the cycle imem_req_valid=1,
// answered exactly one cycle later), decode consumes the head when
// out_valid & decode_ready, and a redirect in the same cycle cancels both.
module fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               FQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_fetch,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          imem_req_valid,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          decode_ready,
    output logic                          out_valid,
    output logic [31:0]                   out_inst,
    output logic [XLEN-1:0]               out_pc,
    output logic                          out_is_branch,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Credit arithmetic needs one extra bit so count + inflight never wraps.
    localparam logic [CNT_W:0]   DEPTH_CREDIT = (CNT_W + 1)'(FQ_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_COUNT  = CNT_W'(FQ_DEPTH);

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    // PC / request tracking
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  req_pc_q;     // address of the request currently in flight
    logic             inflight_q;

    // Fetch queue
    logic [XLEN-1:0]  fq_pc_q   [FQ_DEPTH];
    logic [31:0]      fq_inst_q [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Per-cycle control
    logic             head_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   credit_used;
    logic [XLEN-1:0]  redirect_target;
    logic [6:0]       head_opcode;

    // Low address bits of a redirect are architecturally ignored.
    logic             unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    assign head_valid = (count_q != '0);

    // Redirect overrides everything: no consumption, no fill, no new request.
    assign pop  = head_valid & decode_ready & ~redirect_valid;
    assign push = imem_rsp_valid & inflight_q & ~redirect_valid;

    // Slots committed after this cycle: entries left after the pop plus the
    // one reserved by a request whose response has not arrived yet.
    always_comb begin
        credit_used = {1'b0, count_q}
                    - (CNT_W + 1)'(pop)
                    + (CNT_W + 1)'(inflight_q);
    end

    // Issue only when a returning word is guaranteed a free slot.
    always_comb begin
        issue = ~reset
              & ~stall_fetch
              & ~redirect_valid
              & (credit_used < DEPTH_CREDIT);
    end

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_q;

    // PC advance, in-flight flag and the PC of the outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_target;
            inflight_q <= 1'b0;
        end else if (issue) begin
            req_pc_q   <= pc_q;
            pc_q       <= pc_q + XLEN'(4);
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect flushes the whole queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage: written on push, never cleared (outputs are gated instead).
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc_q[wr_ptr_q]   <= req_pc_q;
            fq_inst_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    // Head presentation straight from queue registers; zero while empty.
    always_comb begin
        out_valid = head_valid;
        out_pc    = '0;
        out_inst  = '0;
        if (head_valid) begin
            out_pc   = fq_pc_q[rd_ptr_q];
            out_inst = fq_inst_q[rd_ptr_q];
        end
    end

    assign head_opcode = out_inst[6:0];

    // Control-flow flag feeds the stall generator; no internal hold here.
    always_comb begin
        out_is_branch = head_valid &
                        ((head_opcode == OPC_BRANCH) |
                         (head_opcode == OPC_JAL)    |
                         (head_opcode == OPC_JALR));
    end

    assign fq_count = count_q;

    // Interface sanity: responses only answer a request, and the credit
    // scheme must keep a push from ever landing on a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && !inflight_q));
            assert (!(push && !pop && (count_q == DEPTH_COUNT)));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based reference model and a
// bench-side 1-cycle instruction memory.
module tb_fetch_stage;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_fetch = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        decode_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_branch;
    logic [2:0]  fq_count;

    fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .decode_ready   (decode_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_is_branch  (out_is_branch),
        .fq_count       (fq_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog: the bench is fixed-length, this only guards against a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // Reference model: fetch queue contents in program order.
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_inflight;

    // Bench memory: request seen last cycle, answered this cycle.
    bit          pend_valid;
    logic [31:0] pend_addr;

    // Values sampled in the most recent cycle, for literal checks.
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;
    logic        s_branch;
    logic [2:0]  s_fq;

    int checks   = 0;
    int failures = 0;

    // Instruction memory contents: ADDI-like words, plus control flow at 0x200.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        case (addr)
            32'h200: return 32'h0000_0063;
            32'h204: return 32'h0000_006F;
            32'h208: return 32'h0000_0067;
            32'h20C: return 32'h0000_0013;
            default: return {addr[26:2], 7'h13};
        endcase
    endfunction

    function automatic bit is_cf(input logic [31:0] inst);
        return (inst[6:0] == 7'h63) || (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        m_pc       = 32'h0;
        m_req_pc   = 32'h0;
        m_inflight = 1'b0;
        pend_valid = 1'b0;
        pend_addr  = 32'h0;
    endtask

    // Driver + compare for one clock cycle. Entered and left at a negedge.
    task automatic cycle(input bit stall, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit     exp_pop;
        bit     exp_issue;
        bit     exp_push;
        entry_t e;
        imem_rsp_valid = pend_valid;
        imem_rsp_data  = pend_valid ? imem_word(pend_addr) : 32'h0;
        stall_fetch    = stall;
        decode_ready   = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        exp_pop   = (mq.size() != 0) && rdy && !redir;
        exp_issue = !stall && !redir &&
                    ((mq.size() - int'(exp_pop) + int'(m_inflight)) < FQ_DEPTH);
        exp_push  = pend_valid && m_inflight && !redir;

        check("req_valid", 32'(imem_req_valid), 32'(exp_issue));
        check("req_addr",  imem_req_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("fq_count",  32'(fq_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            check("out_pc",        out_pc, mq[0].pc);
            check("out_inst",      out_inst, mq[0].inst);
            check("out_is_branch", 32'(out_is_branch), 32'(is_cf(mq[0].inst)));
        end

        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_inst  = out_inst;
        s_branch    = out_is_branch;
        s_fq        = fq_count;

        pend_valid = imem_req_valid;
        pend_addr  = imem_req_addr;

        if (redir) begin
            mq.delete();
            m_inflight = 1'b0;
            m_pc       = {rpc[31:2], 2'b00};
        end else begin
            if (exp_pop) begin
                e = mq.pop_front();
            end
            if (exp_push) begin
                e.pc   = m_req_pc;
                e.inst = imem_word(m_req_pc);
                mq.push_back(e);
            end
            if (exp_issue) begin
                m_req_pc   = m_pc;
                m_pc       = m_pc + 32'd4;
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_fq_count"},  32'(fq_count), 32'h0);
        check({tag, "_req_addr"},  imem_req_addr, 32'h0);
        check({tag, "_out_pc"},    out_pc, 32'h0);
        check({tag, "_out_inst"},  out_inst, 32'h0);
        check({tag, "_branch"},    32'(out_is_branch), 32'h0);
    endtask

    // Full reset with decode ready and no stall, so only reset gates issue.
    task automatic do_reset();
        reset          = 1'b1;
        stall_fetch    = 1'b0;
        decode_ready   = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        reset_model();
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: streaming after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                check("t1_req0_valid", 32'(s_req_valid), 32'h1);
                check("t1_req0_addr",  s_req_addr, 32'h0);
                check("t1_c0_out_valid", 32'(s_out_valid), 32'h0);
            end
            if (i == 1) check("t1_req1_addr", s_req_addr, 32'h4);
            if (i == 2) begin
                check("t1_req2_addr",   s_req_addr, 32'h8);
                check("t1_c2_out_valid", 32'(s_out_valid), 32'h1);
                check("t1_c2_out_pc",   s_out_pc, 32'h0);
            end
            if (i == 3) check("t1_c3_out_pc", s_out_pc, 32'h4);
        end

        // 2: decode backpressure saturates the queue, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 4) check("t2_c4_req_valid", 32'(s_req_valid), 32'h0);
        end
        check("t2_full_count", 32'(s_fq), 32'h4);
        check("t2_full_req_valid", 32'(s_req_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) check("t2_drain_pc0", s_out_pc, 32'h0);
            if (i == 1) check("t2_drain_pc1", s_out_pc, 32'h4);
            if (i == 2) check("t2_drain_pc2", s_out_pc, 32'h8);
            if (i == 3) check("t2_drain_pc3", s_out_pc, 32'hC);
            if (i == 4) check("t2_drain_pc4", s_out_pc, 32'h10);
        end

        // 3: stall gates issue only; queue drains, PC holds
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle((i >= 5) && (i <= 7), 1'b1, 1'b0, 32'h0);
            if (i >= 5 && i <= 7) begin
                check("t3_stall_req_valid", 32'(s_req_valid), 32'h0);
                check("t3_stall_pc_held",   s_req_addr, 32'h14);
            end
            if (i == 7) check("t3_drained", 32'(s_fq), 32'h0);
            if (i == 8) begin
                check("t3_resume_valid", 32'(s_req_valid), 32'h1);
                check("t3_resume_addr",  s_req_addr, 32'h14);
            end
        end

        // 4: redirect with a response in flight and two queued entries
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h103);
        check("t4_pre_count", 32'(s_fq), 32'h2);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_post_count",     32'(s_fq), 32'h0);
        check("t4_post_out_valid", 32'(s_out_valid), 32'h0);
        check("t4_post_req_valid", 32'(s_req_valid), 32'h1);
        check("t4_post_req_addr",  s_req_addr, 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_first_pc", s_out_pc, 32'h100);

        // 5: control-flow detection at the queue head
        cycle(1'b0, 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_beq_inst", s_out_inst, 32'h0000_0063);
        check("t5_beq_flag", 32'(s_branch), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_jal_inst", s_out_inst, 32'h0000_006F);
        check("t5_jal_flag", 32'(s_branch), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_jalr_inst", s_out_inst, 32'h0000_0067);
        check("t5_jalr_flag", 32'(s_branch), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_addi_inst", s_out_inst, 32'h0000_0013);
        check("t5_addi_flag", 32'(s_branch), 32'h0);

        // 6: asynchronous reset in the middle of a cycle
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_pre_count", 32'(s_fq), 32'h3);
        #2;
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        check_reset_outputs("t6_mid");
        reset_model();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                check("t6_restart_valid", 32'(s_req_valid), 32'h1);
                check("t6_restart_addr",  s_req_addr, 32'h0);
            end
            if (i == 2) check("t6_restart_out_pc", s_out_pc, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
